// File: rtl/rr_pulse_arbiter.sv
// -----------------------------------------------------------------------------
// rr_pulse_arbiter
//
// Purpose:
//   Shares one downstream valid/ready channel among TOTAL pulse-driven
//   requesters. Each requester strobes i_rdy[i] for one cycle with a WIDTH-bit
//   word. The word is latched per slot and forwarded downstream in round-robin
//   order. Priority rotates after every transfer, and grants can run
//   back-to-back (one transfer per cycle while i_out_rdy is held high).
//
// Configuration macro:
//   RR_PULSE_ARB_OVERRUN_EN - when defined, builds the sticky per-slot overrun
//                             flags. When undefined, o_overrun is tied to 0
//                             and i_overrun_clr is ignored.
//
// Ports:
//   clk            in   1            system clock, rising edge
//   rst_n          in   1            asynchronous active-low reset
//   i_rdy          in   TOTAL        per-slot one-cycle request strobe
//   i_bus_in       in   TOTAL*WIDTH  request data, slot i = [WIDTH*i +: WIDTH]
//   o_bus_out      out  WIDTH        granted word (registered)
//   o_out_valid    out  1            o_bus_out holds a granted word
//   i_out_rdy      in   1            consumer accepts (transfer = valid & rdy)
//   o_out_selected out  clog2(TOTAL) index of the granted slot (registered)
//   o_busy         out  TOTAL        slot holds an undelivered word
//   o_overrun      out  TOTAL        sticky per-slot overrun flag
//   i_overrun_clr  in   TOTAL        per-slot synchronous overrun clear
// -----------------------------------------------------------------------------
module rr_pulse_arbiter #(
  parameter int TOTAL = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [TOTAL-1:0]           i_rdy,
  input  logic [TOTAL*WIDTH-1:0]     i_bus_in,
  output logic [WIDTH-1:0]           o_bus_out,
  output logic                       o_out_valid,
  input  logic                       i_out_rdy,
  output logic [$clog2(TOTAL)-1:0]   o_out_selected,
  output logic [TOTAL-1:0]           o_busy,
  output logic [TOTAL-1:0]           o_overrun,
  input  logic [TOTAL-1:0]           i_overrun_clr
);

  localparam int SW = $clog2(TOTAL);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_n;
  logic [WIDTH-1:0] r_latch   [TOTAL];
  logic [WIDTH-1:0] w_latch_n [TOTAL];
  logic [TOTAL-1:0] r_pend;
  logic [TOTAL-1:0] w_pend_n;
  logic [TOTAL-1:0] w_xfer_oh;
  logic [TOTAL-1:0] w_clr;
  logic [SW-1:0]    r_ptr;
  logic [SW-1:0]    w_ptr_n;
  logic [SW-1:0]    r_sel;
  logic [SW-1:0]    w_sel_n;
  logic [SW-1:0]    w_idx;
  logic [WIDTH-1:0] r_bus_out;
  logic [WIDTH-1:0] w_bus_out_n;
  logic             r_refill;
  logic             w_refill_n;
  logic             w_xfer;
  logic             w_found;

  // A transfer happens when a granted word meets a ready consumer.
  assign w_xfer = (r_state == S_GRANT) && i_out_rdy;

  // Next latch contents: a strobe in this edge bypasses the stored word.
  always_comb begin
    for (int i = 0; i < TOTAL; i++) begin
      if (i_rdy[i]) begin
        w_latch_n[i] = i_bus_in[WIDTH*i +: WIDTH];
      end else begin
        w_latch_n[i] = r_latch[i];
      end
    end
  end

  // One-hot of the slot being transferred on this edge.
  always_comb begin
    w_xfer_oh = '0;
    if (w_xfer) begin
      w_xfer_oh[r_sel] = 1'b1;
    end else begin
      w_xfer_oh = '0;
    end
  end

  // r_refill marks that the granted slot was re-strobed while held by
  // backpressure: its latch now holds a second, not yet delivered word, so
  // the transfer of the old word must not drop the slot's pending bit.
  assign w_clr    = r_refill ? '0 : w_xfer_oh;
  assign w_pend_n = (r_pend & ~w_clr) | i_rdy;
  assign w_ptr_n  = w_xfer ? r_sel : r_ptr;

  // Round-robin search of the next-state pending vector from w_ptr_n+1.
  always_comb begin
    int            idx;
    logic [SW-1:0] cand;
    w_found = 1'b0;
    w_idx   = '0;
    idx     = 0;
    cand    = '0;
    for (int k = 1; k <= TOTAL; k++) begin
      idx  = (int'(w_ptr_n) + k) % TOTAL;
      cand = SW'(idx);
      if (!w_found && w_pend_n[cand]) begin
        w_found = 1'b1;
        w_idx   = cand;
      end else begin
        w_found = w_found;
      end
    end
  end

  // Grant FSM: next state, granted word/index and refill tracking.
  always_comb begin
    w_state_n   = r_state;
    w_sel_n     = r_sel;
    w_bus_out_n = r_bus_out;
    w_refill_n  = r_refill;
    case (r_state)
      S_IDLE: begin
        w_refill_n = 1'b0;
        if (w_found) begin
          w_state_n   = S_GRANT;
          w_sel_n     = w_idx;
          w_bus_out_n = w_latch_n[w_idx];
        end else begin
          w_state_n = S_IDLE;
        end
      end
      S_GRANT: begin
        if (i_out_rdy) begin
          w_refill_n = 1'b0;
          if (w_found) begin
            w_state_n   = S_GRANT;
            w_sel_n     = w_idx;
            w_bus_out_n = w_latch_n[w_idx];
          end else begin
            w_state_n = S_IDLE;
          end
        end else begin
          // Held by backpressure: word and index are frozen.
          w_state_n  = S_GRANT;
          w_refill_n = r_refill | i_rdy[r_sel];
        end
      end
      default: begin
        w_state_n  = S_IDLE;
        w_refill_n = 1'b0;
      end
    endcase
  end

  // State, pointer, pending, latch and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_sel     <= '0;
      r_bus_out <= '0;
      r_pend    <= '0;
      r_ptr     <= SW'(TOTAL - 1);
      r_refill  <= 1'b0;
      for (int i = 0; i < TOTAL; i++) begin
        r_latch[i] <= '0;
      end
    end else begin
      r_state   <= w_state_n;
      r_sel     <= w_sel_n;
      r_bus_out <= w_bus_out_n;
      r_pend    <= w_pend_n;
      r_ptr     <= w_ptr_n;
      r_refill  <= w_refill_n;
      for (int i = 0; i < TOTAL; i++) begin
        r_latch[i] <= w_latch_n[i];
      end
    end
  end

`ifdef RR_PULSE_ARB_OVERRUN_EN
  logic [TOTAL-1:0] r_overrun;
  logic [TOTAL-1:0] w_ov_set;

  // A strobe on a busy slot that is not being transferred overwrites a word.
  assign w_ov_set = i_rdy & r_pend & ~w_xfer_oh;

  // Sticky overrun flags; a set on the same edge as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= '0;
    end else begin
      r_overrun <= (r_overrun & ~i_overrun_clr) | w_ov_set;
    end
  end

  assign o_overrun = r_overrun;
`else
  logic w_unused_clr;
  assign w_unused_clr = ^i_overrun_clr;
  assign o_overrun    = '0;
`endif

  assign o_out_valid    = (r_state == S_GRANT);
  assign o_bus_out      = r_bus_out;
  assign o_out_selected = r_sel;
  assign o_busy         = r_pend;

endmodule

// File: tb/tb_rr_pulse_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_pulse_arbiter
//
// Self-checking bench for rr_pulse_arbiter (TOTAL=4, WIDTH=8). A table of
// directed vectors with hand-computed outputs is applied one per clock, then
// short hand-written sequences cover async reset mid-grant and the priority
// start point after reset. Overrun expectations follow
// RR_PULSE_ARB_OVERRUN_EN (zero when the macro is undefined).
// -----------------------------------------------------------------------------
module tb_rr_pulse_arbiter;

  localparam int TOTAL = 4;
  localparam int WIDTH = 8;
`ifdef RR_PULSE_ARB_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic [3:0]        rdy;
  logic [31:0]       bus_in;
  logic [7:0]        bus_out;
  logic              out_valid;
  logic              out_rdy;
  logic [1:0]        out_selected;
  logic [3:0]        busy;
  logic [3:0]        overrun;
  logic [3:0]        overrun_clr;

  int tests;
  int fails;

  typedef struct {
    string       name;
    logic [3:0]  rdy;
    logic [31:0] bus;
    logic        ordy;
    logic [3:0]  clr;
    logic        v;
    logic [7:0]  b;
    logic [1:0]  s;
    logic [3:0]  busy;
    logic [3:0]  ovr;
  } vec_t;

  vec_t tbl[$];

  rr_pulse_arbiter #(.TOTAL(TOTAL), .WIDTH(WIDTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_rdy          (rdy),
    .i_bus_in       (bus_in),
    .o_bus_out      (bus_out),
    .o_out_valid    (out_valid),
    .i_out_rdy      (out_rdy),
    .o_out_selected (out_selected),
    .o_busy         (busy),
    .o_overrun      (overrun),
    .i_overrun_clr  (overrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input string n, input logic [3:0] r, input logic [31:0] b_in,
                     input logic o, input logic [3:0] c, input logic v,
                     input logic [7:0] b, input logic [1:0] s,
                     input logic [3:0] bz, input logic [3:0] ov);
    vec_t e;
    e.name = n; e.rdy = r; e.bus = b_in; e.ordy = o; e.clr = c;
    e.v = v; e.b = b; e.s = s; e.busy = bz; e.ovr = ov;
    tbl.push_back(e);
  endtask

  // Compares all outputs at once: {valid, bus_out, selected, busy, overrun}.
  task automatic chk(input string n, input logic v, input logic [7:0] b,
                     input logic [1:0] s, input logic [3:0] bz, input logic [3:0] ov);
    logic [18:0] act;
    logic [18:0] exp;
    act = {out_valid, bus_out, out_selected, busy, overrun};
    exp = {v, b, s, bz, (OVR_EN ? ov : 4'b0000)};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got v=%b bus=%h sel=%0d busy=%b ovr=%b, expected v=%b bus=%h sel=%0d busy=%b ovr=%b",
               n, act[18], act[17:10], act[9:8], act[7:4], act[3:0],
               exp[18], exp[17:10], exp[9:8], exp[7:4], exp[3:0]);
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic [31:0] b_in,
                       input logic o, input logic [3:0] c);
    @(negedge clk);
    rdy = r; bus_in = b_in; out_rdy = o; overrun_clr = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rdy = 4'b0000; bus_in = 32'h0; out_rdy = 1'b0; overrun_clr = 4'b0000;
    rst_n = 1'b0;
    #1;
    chk("reset", 1'b0, 8'h00, 2'd0, 4'b0000, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    // name       rdy      bus_in         ordy  clr      v     bus    sel   busy     ovr
    add("fair0", 4'b1111, 32'h13121110, 1'b1, 4'b0000, 1'b1, 8'h10, 2'd0, 4'b1111, 4'b0000);
    add("fair1", 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 8'h11, 2'd1, 4'b1110, 4'b0000);
    add("fair2", 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 8'h12, 2'd2, 4'b1100, 4'b0000);
    add("fair3", 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 8'h13, 2'd3, 4'b1000, 4'b0000);
    add("fair4", 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h13, 2'd3, 4'b0000, 4'b0000);
    add("sing0", 4'b0001, 32'h000000A5, 1'b1, 4'b0000, 1'b1, 8'hA5, 2'd0, 4'b0001, 4'b0000);
    add("sing1", 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd0, 4'b0000, 4'b0000);
    add("rot0",  4'b0100, 32'h00420000, 1'b1, 4'b0000, 1'b1, 8'h42, 2'd2, 4'b0100, 4'b0000);
    add("rot1",  4'b0101, 32'h00520050, 1'b1, 4'b0000, 1'b1, 8'h50, 2'd0, 4'b0101, 4'b0000);
    add("rot2",  4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 8'h52, 2'd2, 4'b0100, 4'b0000);
    add("rot3",  4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h52, 2'd2, 4'b0000, 4'b0000);
    add("bp0",   4'b0010, 32'h00002200, 1'b0, 4'b0000, 1'b1, 8'h22, 2'd1, 4'b0010, 4'b0000);
    add("bp1",   4'b0010, 32'h00003300, 1'b0, 4'b0000, 1'b1, 8'h22, 2'd1, 4'b0010, 4'b0010);
    add("bp2",   4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b1, 8'h22, 2'd1, 4'b0010, 4'b0010);
    add("bp3",   4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 8'h33, 2'd1, 4'b0010, 4'b0010);
    add("bp4",   4'b0000, 32'h00000000, 1'b1, 4'b0010, 1'b0, 8'h33, 2'd1, 4'b0000, 4'b0000);
    add("ovr0",  4'b0001, 32'h00000060, 1'b0, 4'b0000, 1'b1, 8'h60, 2'd0, 4'b0001, 4'b0000);
    add("ovr1",  4'b1000, 32'h01000000, 1'b0, 4'b0000, 1'b1, 8'h60, 2'd0, 4'b1001, 4'b0000);
    add("ovr2",  4'b1000, 32'h02000000, 1'b0, 4'b1000, 1'b1, 8'h60, 2'd0, 4'b1001, 4'b1000);
    add("ovr3",  4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 8'h02, 2'd3, 4'b1000, 4'b1000);
    add("ovr4",  4'b0000, 32'h00000000, 1'b1, 4'b1000, 1'b0, 8'h02, 2'd3, 4'b0000, 4'b0000);
    add("idle",  4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h02, 2'd3, 4'b0000, 4'b0000);

    foreach (tbl[i]) begin
      drive(tbl[i].rdy, tbl[i].bus, tbl[i].ordy, tbl[i].clr);
      chk(tbl[i].name, tbl[i].v, tbl[i].b, tbl[i].s, tbl[i].busy, tbl[i].ovr);
    end

    // Async reset while a word is granted and held by backpressure.
    drive(4'b0011, 32'h00008180, 1'b0, 4'b0000);
    chk("ar_grant", 1'b1, 8'h80, 2'd0, 4'b0011, 4'b0000);
    drive(4'b0011, 32'h00009190, 1'b0, 4'b0000);
    chk("ar_ovr", 1'b1, 8'h80, 2'd0, 4'b0011, 4'b0011);
    rdy = 4'b0000; bus_in = 32'h0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_async", 1'b0, 8'h00, 2'd0, 4'b0000, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    // After reset the search starts at slot 0; slot 1 wins over slot 2.
    drive(4'b0110, 32'h00727100, 1'b1, 4'b0000);
    chk("pr_first", 1'b1, 8'h71, 2'd1, 4'b0110, 4'b0000);
    drive(4'b0000, 32'h00000000, 1'b1, 4'b0000);
    chk("pr_second", 1'b1, 8'h72, 2'd2, 4'b0100, 4'b0000);
    drive(4'b0000, 32'h00000000, 1'b1, 4'b0000);
    chk("pr_done", 1'b0, 8'h72, 2'd2, 4'b0000, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
